pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage microcpu pipeline. It watches the decode (ID) stage, the execute (EX) stage and the data-memory handshake, and generates:
- the flush input of the ID/EX control register;
- the IF/ID flush;
- a global stall for PC, IF/ID, ID/EX and EX/MEM.
It resolves load-use hazards, taken branches/CALL/RET, and multi-cycle memory accesses.

Parameters:
REG_ADDR_W, 5, register-index width
FLUSH_CYCLES, 1, cycles both flushes stay asserted after a taken branch (min 1, max 15)
MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout_err sets (min 2, max 65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_src1  in  REG_ADDR_W  ID-stage source register 1
id_src2  in  REG_ADDR_W  ID-stage source register 2
id_use_src1  in  1  ID instruction reads src1
id_use_src2  in  1  ID instruction reads src2
ex_alu_dest  in  REG_ADDR_W  EX-stage destination
ex_reg_write_enable  in  1  EX instruction writes a register
ex_mem_rd  in  1  EX instruction is a load
ex_load_pc  in  1  EX resolved a taken branch/CALL/RET (PC reload this cycle)
mem_req  in  1  MEM stage has an active read/write
mem_ready  in  1  data memory completes the request this cycle
pipe_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
pc_stall  out  1  hold PC only
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  drives ID/EX control-register flush
mem_timeout_err  out  1  sticky error flag
hazard_state  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2. Flush counter is 4 bits; wait counter is 16 bits.
- Reset (async, while rst=1):
  - state=RUN, counters=0, mem_timeout_err=0.
  - Outputs are forced to ifid_flush=1, idex_flush=1, pipe_stall=0, pc_stall=0.
- Outputs are combinational from state and current inputs: zero-cycle latency, so the flush/stall is seen at the same edge the hazard would be captured.
- load_use = ex_mem_rd & ex_reg_write_enable & (ex_alu_dest!=0) & ((id_use_src1 & id_src1==ex_alu_dest) | (id_use_src2 & id_src2==ex_alu_dest)). Register 0 never creates a hazard.
- RUN, priority order (highest first):
  1. mem_req & !mem_ready:
     - pipe_stall=1, no flushes.
     - Next state MEM_WAIT, wait counter=1.
     - A simultaneous branch or load-use is frozen and re-evaluated after the wait.
  2. ex_load_pc:
     - ifid_flush=1, idex_flush=1, PC not stalled.
     - If FLUSH_CYCLES>1: next state FLUSH, flush counter=FLUSH_CYCLES-1. Otherwise stay in RUN.
  3. load_use:
     - pc_stall=1, idex_flush=1 for exactly one cycle (bubble). Stay in RUN.
     - The bubble clears ex_mem_rd, so there is no re-detection.
  4. Otherwise all outputs are 0.
- FLUSH:
  - ifid_flush=idex_flush=1; counter decrements each cycle; return to RUN when the counter reaches 1.
  - mem_req & !mem_ready has priority: go to MEM_WAIT and abandon the remaining flush count.
  - A new ex_load_pc while in FLUSH is ignored, because EX is being flushed.
- MEM_WAIT:
  - pipe_stall=1, flushes 0.
  - mem_ready=1: pipe_stall is deasserted that same cycle; next state RUN.
  - mem_req dropping without mem_ready: return to RUN; this is an illegal protocol, and mem_timeout_err is not set.
  - Wait counter saturates at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, mem_timeout_err sets and stays set until rst. The FSM stays in MEM_WAIT.
- pc_stall=1 whenever pipe_stall=1.
- hazard_state reflects the registered state.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds 32-bit outputs stall_cycle_cnt (cycles with pc_stall=1) and flush_cycle_cnt (cycles with idex_flush=1, excluding reset).
  - Both saturate at 0xFFFFFFFF.
  - Both are cleared by rst and by a new input perf_clr (1 bit, synchronous, has priority over increment).
- Not defined: these ports and perf_clr do not exist, and no counter logic is generated.

Decomposition:
- Package hazard_pkg holds the state enum (RUN/FLUSH/MEM_WAIT), the 2-bit state width, and the counter widths.
- One natural sub-module: hazard_detect, the purely combinational load_use compare. It is reusable later for a forwarding unit.

Test Plan:
- Load-use: ex_mem_rd=1, ex_reg_write_enable=1, ex_alu_dest=5, id_src1=5, id_use_src1=1 -> pc_stall=1, idex_flush=1 for 1 cycle, then 0. Same stimulus with dest=0 -> no stall.
- Branch: ex_load_pc=1 for 1 cycle with FLUSH_CYCLES=3 -> ifid_flush=idex_flush=1 for 3 consecutive cycles; hazard_state goes 0,1,1,0.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> pipe_stall=1 for 4 cycles, 0 on the ready cycle; state returns to RUN.
- Simultaneous: mem_req & !mem_ready with ex_load_pc=1 -> only pipe_stall. After mem_ready, the held ex_load_pc produces flushes.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 -> mem_timeout_err=1 after 8 stalled cycles and stays 1 after mem_ready. Clears only on rst.
- Async reset mid-FLUSH: assert rst between clock edges -> ifid_flush=idex_flush=1 immediately, state=RUN, counters 0. With HAZARD_PERF_EN, perf counters also read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and widths for the pipeline hazard controller.
// Holds the FSM state encoding, counter widths and a saturating helper.
package hazard_pkg;

  localparam int STATE_W     = 2;
  localparam int FLUSH_CNT_W = 4;
  localparam int WAIT_CNT_W  = 16;
  localparam int PERF_CNT_W  = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(
    input logic [PERF_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: pure combinational load-use compare between ID and EX.
// Register 0 is hard-wired zero and never produces a hazard.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic [REG_ADDR_W-1:0] ex_alu_dest,
  input  logic                  ex_reg_write_enable,
  input  logic                  ex_mem_rd,
  output logic                  load_use
);

  logic hit1;
  logic hit2;
  logic dest_nz;

  // Match each used ID source against a pending load destination.
  always_comb begin
    hit1     = id_use_src1 && (id_src1 == ex_alu_dest);
    hit2     = id_use_src2 && (id_src2 == ex_alu_dest);
    dest_nz  = |ex_alu_dest;
    load_use = ex_mem_rd && ex_reg_write_enable
               && dest_nz && (hit1 || hit2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic [REG_ADDR_W-1:0] ex_alu_dest,
  input  logic                  ex_reg_write_enable,
  input  logic                  ex_mem_rd,
  input  logic                  ex_load_pc,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pipe_stall,
  output logic                  pc_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  mem_timeout_err,
  output logic [STATE_W-1:0]    hazard_state
`ifdef HAZARD_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [PERF_CNT_W-1:0] stall_cycle_cnt,
  output logic [PERF_CNT_W-1:0] flush_cycle_cnt
`endif
);

  localparam logic FLUSH_MULTI = (FLUSH_CYCLES > 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT =
    FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX =
    WAIT_CNT_W'(MEM_TIMEOUT);

  hz_state_e               state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    err_q, err_d;

  logic load_use;
  logic mem_busy;
  logic pipe_stall_c;
  logic pc_stall_c;
  logic ifid_c;
  logic idex_c;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detect (
    .id_src1             (id_src1),
    .id_src2             (id_src2),
    .id_use_src1         (id_use_src1),
    .id_use_src2         (id_use_src2),
    .ex_alu_dest         (ex_alu_dest),
    .ex_reg_write_enable (ex_reg_write_enable),
    .ex_mem_rd           (ex_mem_rd),
    .load_use            (load_use)
  );

  assign mem_busy = mem_req && !mem_ready;

  // Next-state and same-cycle stall/flush decisions.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    pipe_stall_c = 1'b0;
    pc_stall_c   = 1'b0;
    ifid_c       = 1'b0;
    idex_c       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          pipe_stall_c = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = WAIT_CNT_W'(1);
        end else if (ex_load_pc) begin
          ifid_c = 1'b1;
          idex_c = 1'b1;
          if (FLUSH_MULTI) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (load_use) begin
          pc_stall_c = 1'b1;
          idex_c     = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_busy) begin
          pipe_stall_c = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = WAIT_CNT_W'(1);
          flush_cnt_d  = '0;
        end else begin
          ifid_c = 1'b1;
          idex_c = 1'b1;
          if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          pipe_stall_c = 1'b1;
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (wait_cnt_d == WAIT_MAX) begin
            err_d = 1'b1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
        wait_cnt_d  = '0;
      end
    endcase
    pc_stall_c = pc_stall_c || pipe_stall_c;
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pipe_stall      = !rst && pipe_stall_c;
  assign pc_stall        = !rst && pc_stall_c;
  assign ifid_flush      = rst || ifid_c;
  assign idex_flush      = rst || idex_c;
  assign mem_timeout_err = err_q;
  assign hazard_state    = state_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_perf_q, flush_cnt_perf_d;

  // Saturating cycle counters; a clear wins over a count.
  always_comb begin
    stall_cnt_d      = stall_cnt_q;
    flush_cnt_perf_d = flush_cnt_perf_q;
    if (perf_clr) begin
      stall_cnt_d      = '0;
      flush_cnt_perf_d = '0;
    end else begin
      if (pc_stall_c) stall_cnt_d = sat_inc(stall_cnt_q);
      if (idex_c) flush_cnt_perf_d = sat_inc(flush_cnt_perf_q);
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q      <= '0;
      flush_cnt_perf_q <= '0;
    end else begin
      stall_cnt_q      <= stall_cnt_d;
      flush_cnt_perf_q <= flush_cnt_perf_d;
    end
  end

  assign stall_cycle_cnt = stall_cnt_q;
  assign flush_cycle_cnt = flush_cnt_perf_q;
`endif

endmodule
